// File: rtl/ace_snoop_resp_collector.sv
// Broadcasts one snoop to the masked AC ports, merges every CR response into one crresp_t.
// Single port with all readies high: request at cycle 0, AC at 1, CR at 2, agg_valid_o at 3; any backpressure only stretches SNOOP.
module ace_snoop_resp_collector #(
  parameter int unsigned NoPorts   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxWidth  = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   snp_req_valid_i,
  output logic                   snp_req_ready_o,
  input  logic [AddrWidth-1:0]   snp_addr_i,
  input  logic [3:0]             snp_type_i,
  input  logic [NoPorts-1:0]     snp_mask_i,
  output logic [NoPorts-1:0]     ac_valid_o,
  input  logic [NoPorts-1:0]     ac_ready_i,
  output logic [AddrWidth-1:0]   ac_addr_o,
  output logic [3:0]             ac_snoop_o,
  input  logic [NoPorts-1:0]     cr_valid_i,
  output logic [NoPorts-1:0]     cr_ready_o,
  input  logic [NoPorts*5-1:0]   cr_resp_i,
  output logic                   agg_valid_o,
  input  logic                   agg_ready_i,
  output logic [4:0]             agg_resp_o,
  output logic [NoPorts-1:0]     agg_data_vec_o,
  output logic [IdxWidth-1:0]    agg_data_port_o
);

  // crresp_t bit positions: {wasUnique, isShared, passDirty, error, dataTransfer}
  localparam int unsigned DtBit  = 0;
  localparam int unsigned ErrBit = 1;
  localparam int unsigned PdBit  = 2;

  typedef enum logic [1:0] {IDLE, SNOOP, RESP} state_e;

  state_e               state_q, state_d;
  logic [NoPorts-1:0]   ac_pending_q, ac_pending_d;
  logic [NoPorts-1:0]   cr_pending_q, cr_pending_d;
  logic [NoPorts-1:0]   data_vec_q, data_vec_d;
  logic [4:0]           resp_q, resp_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           type_q, type_d;
  logic [NoPorts-1:0]   ac_hs, cr_hs;
  logic [4:0]           port_resp;
  logic [IdxWidth-1:0]  data_port;

  always_comb begin
    state_d         = state_q;
    ac_pending_d    = ac_pending_q;
    cr_pending_d    = cr_pending_q;
    data_vec_d      = data_vec_q;
    resp_d          = resp_q;
    addr_d          = addr_q;
    type_d          = type_q;
    snp_req_ready_o = 1'b0;
    ac_valid_o      = '0;
    cr_ready_o      = '0;
    agg_valid_o     = 1'b0;
    ac_hs           = '0;
    cr_hs           = '0;
    port_resp       = '0;
    case (state_q)
      IDLE: begin
        snp_req_ready_o = 1'b1;
        if (snp_req_valid_i) begin
          addr_d       = snp_addr_i;
          type_d       = snp_type_i;
          ac_pending_d = snp_mask_i;
          cr_pending_d = snp_mask_i;
          resp_d       = '0;
          data_vec_d   = '0;
          state_d      = (snp_mask_i == '0) ? RESP : SNOOP;
        end
      end
      SNOOP: begin
        ac_valid_o   = ac_pending_q;
        // A port's CR is only accepted once its AC has been taken in an earlier cycle.
        cr_ready_o   = cr_pending_q & ~ac_pending_q;
        ac_hs        = ac_valid_o & ac_ready_i;
        cr_hs        = cr_ready_o & cr_valid_i;
        ac_pending_d = ac_pending_q & ~ac_hs;
        cr_pending_d = cr_pending_q & ~cr_hs;
        for (int i = 0; i < int'(NoPorts); i++) begin
          if (cr_hs[i]) begin
            port_resp = cr_resp_i[5*i +: 5];
            if (port_resp[PdBit] && !port_resp[DtBit]) begin
              port_resp[ErrBit] = 1'b1;
            end
            resp_d        = resp_d | port_resp;
            data_vec_d[i] = port_resp[DtBit];
          end
        end
        if (cr_pending_d == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        agg_valid_o = 1'b1;
        if (agg_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_port = '0;
    for (int i = int'(NoPorts) - 1; i >= 0; i--) begin
      if (data_vec_q[i]) begin
        data_port = IdxWidth'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ac_pending_q <= '0;
      cr_pending_q <= '0;
      data_vec_q   <= '0;
      resp_q       <= '0;
      addr_q       <= '0;
      type_q       <= '0;
    end else begin
      state_q      <= state_d;
      ac_pending_q <= ac_pending_d;
      cr_pending_q <= cr_pending_d;
      data_vec_q   <= data_vec_d;
      resp_q       <= resp_d;
      addr_q       <= addr_d;
      type_q       <= type_d;
    end
  end

  assign ac_addr_o       = addr_q;
  assign ac_snoop_o      = type_q;
  assign agg_resp_o      = (state_q == RESP) ? resp_q : '0;
  assign agg_data_vec_o  = (state_q == RESP) ? data_vec_q : '0;
  assign agg_data_port_o = (state_q == RESP) ? data_port : '0;

endmodule

// File: tb/tb_ace_snoop_resp_collector.sv
// Directed cases plus randomized transactions checked against a set-based response model.
module tb_ace_snoop_resp_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snp_req_valid;
  logic        snp_req_ready;
  logic [63:0] snp_addr;
  logic [3:0]  snp_type;
  logic [3:0]  snp_mask;
  logic [3:0]  ac_valid;
  logic [3:0]  ac_ready;
  logic [63:0] ac_addr;
  logic [3:0]  ac_snoop;
  logic [3:0]  cr_valid;
  logic [3:0]  cr_ready;
  logic [19:0] cr_resp;
  logic        agg_valid;
  logic        agg_ready;
  logic [4:0]  agg_resp;
  logic [3:0]  agg_data_vec;
  logic [1:0]  agg_data_port;
  logic [4:0]  rsp [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign cr_resp = {rsp[3], rsp[2], rsp[1], rsp[0]};

  ace_snoop_resp_collector #(.NoPorts(4), .AddrWidth(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .snp_req_valid_i(snp_req_valid), .snp_req_ready_o(snp_req_ready),
    .snp_addr_i(snp_addr), .snp_type_i(snp_type), .snp_mask_i(snp_mask),
    .ac_valid_o(ac_valid), .ac_ready_i(ac_ready), .ac_addr_o(ac_addr), .ac_snoop_o(ac_snoop),
    .cr_valid_i(cr_valid), .cr_ready_o(cr_ready), .cr_resp_i(cr_resp),
    .agg_valid_o(agg_valid), .agg_ready_i(agg_ready), .agg_resp_o(agg_resp),
    .agg_data_vec_o(agg_data_vec), .agg_data_port_o(agg_data_port)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issues a request from IDLE; returns in the cycle after the handshake with scrambled request inputs.
  task automatic req(input logic [3:0] m, input logic [63:0] a, input logic [3:0] t);
    chk("req_ready", snp_req_ready, 1);
    snp_req_valid = 1'b1;
    snp_mask = m;
    snp_addr = a;
    snp_type = t;
    step();
    snp_req_valid = 1'b0;
    snp_mask = 4'($urandom);
    snp_addr = {$urandom, $urandom};
    snp_type = 4'($urandom);
  endtask

  task automatic check_agg(input logic [4:0] r, input logic [3:0] v, input logic [1:0] p);
    chk("agg_valid", agg_valid, 1);
    chk("agg_resp", agg_resp, r);
    chk("agg_vec", agg_data_vec, v);
    chk("agg_port", agg_data_port, p);
  endtask

  task automatic finish_resp();
    agg_ready = 1'b1;
    step();
    agg_ready = 1'b0;
    chk("post_idle_ready", snp_req_ready, 1);
    chk("post_idle_agg", agg_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  m, acd, crd, ev;
    logic [4:0]  er, r;
    logic [1:0]  ep;
    logic [63:0] a;
    logic [3:0]  t;
    bit          done;

    rst_n = 1'b0;
    snp_req_valid = 1'b0; snp_addr = '0; snp_type = '0; snp_mask = '0;
    ac_ready = '0; cr_valid = '0; agg_ready = 1'b0;
    for (int i = 0; i < 4; i++) rsp[i] = '0;
    #1;
    chk("rst_req_ready", snp_req_ready, 1);
    chk("rst_ac_valid", ac_valid, 0);
    chk("rst_cr_ready", cr_ready, 0);
    chk("rst_agg_valid", agg_valid, 0);
    chk("rst_ac_addr", ac_addr, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Two ports, port 1 returns data.
    ac_ready = 4'hF; cr_valid = 4'b0110;
    rsp[1] = 5'b01001; rsp[2] = 5'b00000;
    req(4'b0110, 64'h80, 4'h1);
    chk("d1_ac_valid", ac_valid, 4'b0110);
    chk("d1_ac_addr", ac_addr, 64'h80);
    chk("d1_ac_snoop", ac_snoop, 4'h1);
    chk("d1_cr_ready_c1", cr_ready, 0);
    step();
    chk("d1_cr_ready_c2", cr_ready, 4'b0110);
    chk("d1_agg_c2", agg_valid, 0);
    step();
    check_agg(5'b01001, 4'b0010, 2'd1);
    finish_resp();
    cr_valid = '0;

    // Empty mask goes straight to a zero response.
    ac_ready = '0;
    req(4'b0000, 64'h40, 4'h2);
    check_agg(5'b0, 4'b0, 2'd0);
    chk("d2_ac_valid", ac_valid, 0);
    finish_resp();

    // Port 3 CR held off until after its delayed AC handshake.
    ac_ready = 4'b0111; cr_valid = 4'b1000; rsp[3] = 5'b01000;
    req(4'b1000, 64'h100, 4'h3);
    for (int c = 1; c <= 5; c++) begin
      chk("d3_cr_ready_held", cr_ready[3], 0);
      chk("d3_ac_valid", ac_valid, 4'b1000);
      chk("d3_agg_early", agg_valid, 0);
      if (c == 5) ac_ready = 4'hF;
      step();
    end
    chk("d3_cr_ready_c6", cr_ready, 4'b1000);
    step();
    check_agg(5'b01000, 4'b0000, 2'd0);
    finish_resp();
    cr_valid = '0;

    // All four ports answer in the same cycle.
    ac_ready = 4'hF;
    rsp[0] = 5'b01000; rsp[1] = 5'b00000; rsp[2] = 5'b00001; rsp[3] = 5'b00001;
    req(4'hF, 64'h200, 4'h4);
    chk("d4_ac_valid", ac_valid, 4'hF);
    step();
    cr_valid = 4'hF;
    chk("d4_cr_ready", cr_ready, 4'hF);
    step();
    cr_valid = '0;
    check_agg(5'b01001, 4'b1100, 2'd2);
    finish_resp();

    // passDirty without data forces error; response held under backpressure.
    rsp[0] = 5'b00100; cr_valid = 4'b0001;
    req(4'b0001, 64'h300, 4'h5);
    step(); step();
    for (int c = 0; c < 4; c++) begin
      check_agg(5'b00110, 4'b0000, 2'd0);
      chk("d5_req_ready_held", snp_req_ready, 0);
      step();
    end
    finish_resp();
    cr_valid = '0;

    // Reset during SNOOP abandons the transaction.
    ac_ready = '0;
    req(4'b0011, 64'h1234, 4'h5);
    chk("d6_ac_valid", ac_valid, 4'b0011);
    #1 rst_n = 1'b0;
    #1;
    chk("d6_rst_ac_valid", ac_valid, 0);
    chk("d6_rst_req_ready", snp_req_ready, 1);
    chk("d6_rst_ac_addr", ac_addr, 0);
    chk("d6_rst_cr_ready", cr_ready, 0);
    step();
    rst_n = 1'b1;
    ac_ready = 4'hF; cr_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("d6_no_stale_agg", agg_valid, 0);
      chk("d6_idle_ready", snp_req_ready, 1);
      chk("d6_idle_ac", ac_valid, 0);
    end
    cr_valid = '0;

    // Randomized transactions with random AC/CR/agg backpressure.
    for (int n = 0; n < 60; n++) begin
      m = 4'($urandom);
      a = {$urandom, $urandom};
      t = 4'($urandom);
      for (int i = 0; i < 4; i++) rsp[i] = 5'($urandom);
      er = '0; ev = '0; ep = '0;
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          r = rsp[i];
          if (r[2] && !r[0]) r[1] = 1'b1;
          er = er | r;
          ev[i] = r[0];
        end
      end
      for (int i = 3; i >= 0; i--) if (ev[i]) ep = 2'(i);
      ac_ready = 4'($urandom);
      cr_valid = 4'($urandom);
      req(m, a, t);
      acd = '0; crd = '0; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        if (agg_valid) begin
          done = 1'b1;
        end else begin
          chk("rnd_still_pending", (crd != m), 1);
          chk("rnd_ac_valid", ac_valid, m & ~acd);
          chk("rnd_cr_ready", cr_ready, m & acd & ~crd);
          chk("rnd_ac_addr", ac_addr, a);
          chk("rnd_ac_snoop", ac_snoop, t);
          ac_ready = 4'($urandom);
          cr_valid = 4'($urandom);
          #1;
          acd = acd | (ac_valid & ac_ready);
          crd = crd | (cr_valid & cr_ready);
          step();
        end
      end
      chk("rnd_timeout", done, 1);
      chk("rnd_all_answered", crd, m);
      check_agg(er, ev, ep);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        step();
        check_agg(er, ev, ep);
      end
      finish_resp();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
